uart_rx_frontend: RTL

// - UART receive front end feeding DMI_UART_TAP: deserialises the RX line, decodes command escapes and buffers bytes in a FIFO.
// - Output side matches the TAP receive interface: DATA_REC_O / CMD_REC_O show the FIFO head, RX_EMPTY_O flags empty, READ_I pops one entry.
// - Sits between the board UART pin and the TAP in the debug transport path.
//

---
 rtl/uart_rx_frontend.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 2-flop synchroniser, 8N1/8E1 deserialiser, escape decoder and FWFT FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames (adds a parity state and parity check).
module uart_rx_frontend #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  HEADER       = 8'h01
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic       RX_I,
  input  logic       READ_I,
  output logic [7:0] DATA_REC_O,
  output logic       CMD_REC_O,
  output logic       RX_EMPTY_O,
  output logic       FRAME_ERR_O,
  output logic       OVERRUN_O
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0]  HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0]  BitLoad  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [AddrW:0]   FullCnt  = (AddrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e state_q, state_d;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q, byte_q;
  logic            byte_vld_q, frame_err_q, overrun_q, esc_q, esc_d;
  logic            tick, start_edge, stop_ok;
  logic            load_half, load_bit, shift_en, stop_en;
  logic            push, pop, full, wr_en, overrun_d;
  logic [8:0]      push_entry, head;
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   count_q;
  logic [8:0]       mem_q [FIFO_DEPTH];

  // Synchroniser and previous-sample flop for falling-edge detection; idle line is high.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX_I;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign tick       = (cnt_q == '0);
  assign start_edge = rx_prev_q & ~rx_sync_q;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_edge) state_d = StStart;
      StStart: if (tick) state_d = rx_sync_q ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
      StData:   if (tick && bit_idx_q == 3'd7) state_d = StParity;
      StParity: if (tick) state_d = StStop;
`else
      StData:  if (tick && bit_idx_q == 3'd7) state_d = StStop;
`endif
      StStop:  if (tick) state_d = rx_sync_q ? StIdle : StBreak;
      StBreak: if (rx_sync_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    load_bit  = 1'b0;
    shift_en  = 1'b0;
    stop_en   = 1'b0;
    unique case (state_q)
      StIdle:  load_half = start_edge;
      StStart: load_bit  = tick & ~rx_sync_q;
      StData: begin
        shift_en = tick;
        load_bit = tick;
      end
`ifdef UART_RX_PARITY_EN
      StParity: load_bit = tick;
`endif
      StStop:  stop_en = tick;
      default: ;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;

  // Even parity: data bits plus parity bit must XOR to zero.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI)                                   par_bad_q <= 1'b0;
    else if (state_q == StParity && tick)          par_bad_q <= ^{shift_q, rx_sync_q};
  end

  assign stop_ok = rx_sync_q & ~par_bad_q;
`else
  assign stop_ok = rx_sync_q;
`endif

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (load_half)      cnt_q <= HalfLoad;
      else if (load_bit)  cnt_q <= BitLoad;
      else if (!tick)     cnt_q <= cnt_q - CntW'(1);
      if (load_half)      bit_idx_q <= '0;
      else if (shift_en)  bit_idx_q <= bit_idx_q + 3'd1;
      if (shift_en)       shift_q <= {rx_sync_q, shift_q[7:1]};
      if (stop_en)        byte_q <= shift_q;
      byte_vld_q  <= stop_en & stop_ok;
      frame_err_q <= stop_en & ~stop_ok;
    end
  end

  // Escape decoder: a HEADER byte marks the next byte as a command; HEADER,HEADER is literal 8'h01.
  always_comb begin
    esc_d      = esc_q;
    push       = 1'b0;
    push_entry = '0;
    if (frame_err_q) begin
      esc_d = 1'b0;
    end else if (byte_vld_q) begin
      if (!esc_q && byte_q == HEADER) begin
        esc_d = 1'b1;
      end else if (esc_q) begin
        esc_d      = 1'b0;
        push       = 1'b1;
        push_entry = (byte_q == HEADER) ? {1'b0, 8'h01} : {1'b1, byte_q};
      end else begin
        push       = 1'b1;
        push_entry = {1'b0, byte_q};
      end
    end
  end

  assign pop       = READ_I & (count_q != '0);
  assign full      = (count_q == FullCnt);
  assign wr_en     = push & (~full | pop);
  assign overrun_d = push & full & ~pop;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      esc_q     <= 1'b0;
      overrun_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      esc_q     <= esc_d;
      overrun_q <= overrun_d;
      if (wr_en) wptr_q <= wptr_q + AddrW'(1);
      if (pop)   rptr_q <= rptr_q + AddrW'(1);
      if (wr_en && !pop)      count_q <= count_q + (AddrW + 1)'(1);
      else if (!wr_en && pop) count_q <= count_q - (AddrW + 1)'(1);
    end
  end

  always_ff @(posedge CLK_I) begin
    if (wr_en) mem_q[wptr_q] <= push_entry;
  end

  assign head        = mem_q[rptr_q];
  assign RX_EMPTY_O  = (count_q == '0);
  assign DATA_REC_O  = RX_EMPTY_O ? 8'h00 : head[7:0];
  assign CMD_REC_O   = ~RX_EMPTY_O & head[8];
  assign FRAME_ERR_O = frame_err_q;
  assign OVERRUN_O   = overrun_q;

endmodule
